// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the multi-cycle mul/div sequencer.
//   ALU control codes of the ops it owns, FSM state encoding, counter width,
//   and a small decode helper for recognising those codes.
package muldiv_pkg;
  localparam logic [3:0] ALU_MUL = 4'b1001;
  localparam logic [3:0] ALU_DIV = 4'b1101;
  localparam logic [3:0] ALU_REM = 4'b1110;

  localparam int MD_XLEN = 32;
  localparam int CNT_W   = $clog2(MD_XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_mdu_op(input logic [3:0] code);
    return (code == ALU_MUL) || (code == ALU_DIV) || (code == ALU_REM);
  endfunction
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: EX-stage <-> mul/div sequencer handshake.
//   master (EX side): drives start, alu_control_ex, op_a, op_b, flush;
//                     observes stall_req, busy, done, result.
//   slave  (muldiv_seq): the mirror image.
interface muldiv_seq_if
  import muldiv_pkg::*;
#(parameter int XLEN = MD_XLEN);
  logic            start;
  logic [3:0]      alu_control_ex;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            stall_req;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, alu_control_ex, op_a, op_b, flush,
                  input  stall_req, busy, done, result);
  modport slave  (input  start, alu_control_ex, op_a, op_b, flush,
                  output stall_req, busy, done, result);
endinterface

// File: rtl/muldiv_seq_div_step.sv
// div_step: one restoring-division iteration (combinational).
//   rem_in  : restored partial remainder (always < divisor, so XLEN bits fit)
//   dvd_msb : next dividend bit shifted into the remainder
//   divisor : divisor magnitude
//   rem_out : next restored partial remainder
//   q_bit   : quotient bit produced by this iteration
module div_step
  import muldiv_pkg::*;
#(parameter int XLEN = MD_XLEN)
(
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);
  // Trial subtract needs one extra bit: the shifted remainder can reach 2^XLEN.
  logic [XLEN:0] shifted, diff;

  assign shifted = {rem_in, dvd_msb};
  assign diff    = shifted - {1'b0, divisor};
  assign q_bit   = ~diff[XLEN];
  // When q_bit=0 the shifted value is below the divisor, so its MSB is 0.
  assign rem_out = q_bit ? diff[XLEN-1:0] : shifted[XLEN-1:0];
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative mulw/divw/remw sequencer beside the EX-stage ALU.
//   clk, rst : clock, async active-high reset
//   bus      : muldiv_seq_if.slave (start/alu_control_ex/op_a/op_b/flush in;
//              stall_req/busy/done/result out)
// Works on operand magnitudes, one bit per cycle, then sign-corrects the
// result as it is written on entry to DONE.
module muldiv_seq
  import muldiv_pkg::*;
#(parameter int XLEN = MD_XLEN)
(
  input  logic        clk,
  input  logic        rst,
  muldiv_seq_if.slave bus
);
  localparam int              CW      = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CW-1:0]   LAST    = CW'(XLEN-1);

  function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
    return v[XLEN-1] ? -v : v;
  endfunction

  state_e            state, state_nxt;
  logic [CW-1:0]     cnt;
  logic [2*XLEN-1:0] acc, mcand, acc_nxt;
  logic [XLEN-1:0]   opb_mag;   // multiplier (shifts right) or divisor (static)
  logic [XLEN-1:0]   dvd;       // dividend bits shift out, quotient bits shift in
  logic [XLEN-1:0]   prem, prem_nxt, dvd_nxt;
  logic              q_bit, neg_q, neg_r, is_rem, busy_q;
  logic [XLEN-1:0]   result_q;

  logic            accept, is_div, div_zero, div_ovf, special, last;
  logic [XLEN-1:0] spec_val, mul_lo, mul_fin, div_fin;

  assign accept   = bus.start & (state == IDLE) & is_mdu_op(bus.alu_control_ex) & ~bus.flush;
  assign is_div   = (bus.alu_control_ex == ALU_DIV);
  assign div_zero = (bus.op_b == '0);
  assign div_ovf  = (bus.op_a == MIN_NEG) & (bus.op_b == '1);
  assign special  = (bus.alu_control_ex != ALU_MUL) & (div_zero | div_ovf);
  assign last     = (cnt == LAST);

  // Special cases bypass the iteration and are already final (no sign fixup).
  assign spec_val = div_zero ? (is_div ? '1 : bus.op_a)
                             : (is_div ? bus.op_a : '0);

  assign acc_nxt = acc + (opb_mag[0] ? mcand : '0);

  div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (prem),
    .dvd_msb (dvd[XLEN-1]),
    .divisor (opb_mag),
    .rem_out (prem_nxt),
    .q_bit   (q_bit)
  );
  assign dvd_nxt = {dvd[XLEN-2:0], q_bit};

  // Final values use this cycle's step output so result is ready in DONE.
  assign mul_lo  = acc_nxt[XLEN-1:0];
  assign mul_fin = neg_q ? -mul_lo : mul_lo;
  assign div_fin = is_rem ? (neg_r ? -prem_nxt : prem_nxt)
                          : (neg_q ? -dvd_nxt  : dvd_nxt);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)
              state_nxt = (bus.alu_control_ex == ALU_MUL) ? MUL : (special ? DONE : DIV);
      MUL,
      DIV:  if (bus.flush)  state_nxt = IDLE;
            else if (last)  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      opb_mag  <= '0;
      dvd      <= '0;
      prem     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      is_rem   <= 1'b0;
      result_q <= '0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == MUL) || (state_nxt == DIV);
      case (state)
        IDLE: if (accept) begin
          cnt     <= '0;
          acc     <= '0;
          prem    <= '0;
          mcand   <= {{XLEN{1'b0}}, mag(bus.op_a)};
          dvd     <= mag(bus.op_a);
          opb_mag <= mag(bus.op_b);
          neg_q   <= bus.op_a[XLEN-1] ^ bus.op_b[XLEN-1];
          neg_r   <= bus.op_a[XLEN-1];
          is_rem  <= (bus.alu_control_ex == ALU_REM);
          if (special) result_q <= spec_val;
        end
        MUL: begin
          acc     <= acc_nxt;
          mcand   <= mcand << 1;
          opb_mag <= opb_mag >> 1;
          cnt     <= cnt + 1'b1;
          if (last && !bus.flush) result_q <= mul_fin;
        end
        DIV: begin
          prem <= prem_nxt;
          dvd  <= dvd_nxt;
          cnt  <= cnt + 1'b1;
          if (last && !bus.flush) result_q <= div_fin;
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_req = accept | (state == MUL) | (state == DIV);
  assign bus.busy      = busy_q;
  assign bus.done      = (state == DONE);
  assign bus.result    = result_q;
endmodule
